// File: rtl/wb_master_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter_pkg
// Shared definitions for the Wishbone master arbiter slice: default
// parameter values and the one-hot FSM state encoding.
// ---------------------------------------------------------------------------
package wb_master_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;   // requesters, 2..8
  localparam int IDX_W_DEF   = 2;   // ceil(log2(NUM_REQ)), 1..3
  localparam int DATA_WL_DEF = 16;  // matches wb_interface data_wl
  localparam int ADR_WL_DEF  = 16;  // matches wb_interface adr_wl

  // One-hot, 4-bit transaction sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } state_t;

endpackage

// File: rtl/wb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter_if
// Command/response link between the arbiter and the chip-side port of
// wb_interface.
//   start  : 1-cycle transaction launch pulse        (to start_i)
//   we     : write enable                            (to we_i)
//   addr   : transaction address                     (to addr_i)
//   wdata  : write data                              (to data_i)
//   busy   : transaction in flight                   (from busy_o)
//   valid  : transaction finished, rdata valid       (from valid_o)
//   rdata  : read data                               (from data_o)
// Modports: master = arbiter side, slave = wb_interface side.
// ---------------------------------------------------------------------------
interface wb_master_arbiter_if
  import wb_master_arbiter_pkg::*;
#(
  parameter int DATA_WL = DATA_WL_DEF,
  parameter int ADR_WL  = ADR_WL_DEF
);
  logic               start;
  logic               we;
  logic [ADR_WL-1:0]  addr;
  logic [DATA_WL-1:0] wdata;
  logic               busy;
  logic               valid;
  logic [DATA_WL-1:0] rdata;

  modport master (output start, we, addr, wdata, input busy, valid, rdata);
  modport slave  (input start, we, addr, wdata, output busy, valid, rdata);
endinterface

// File: rtl/wb_rr_picker.sv
// ---------------------------------------------------------------------------
// wb_rr_picker
// Combinational winner selection.
//   req : request vector          ptr : index of the last winner
//   win : selected requester      any : at least one request pending
// Default: round-robin, search starts at ptr+1 and wraps modulo NUM_REQ.
// With WB_ARB_FIXED_PRIO_EN defined: lowest asserted index wins, ptr ignored.
// ---------------------------------------------------------------------------
module wb_rr_picker
  import wb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any
);

`ifdef WB_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held (no latch).
    win = '0;
    any = |req;
    // Walk downward so the lowest asserted index is the last assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win = IDX_W'(i);
    end
  end
`else
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held (no latch).
    win = '0;
    any = |req;
    sum = '0;
    idx = '0;
    // Walk the search order backwards (farthest offset first) so the nearest
    // pending requester after ptr is the last assignment and wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (req[idx]) win = idx;
    end
  end
`endif

endmodule

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
// Shares one wb_interface master port among NUM_REQ requesters, one
// transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ports:
//   clk, a_reset_l : clock, asynchronous active-low reset
//   req            : per-requester request level
//   req_we         : per-requester write enable
//   req_addr       : flattened addresses, requester k at [k*ADR_WL +: ADR_WL]
//   req_data       : flattened write data, same packing
//   gnt            : one-hot 1-cycle accept pulse (during ISSUE)
//   rsp_valid      : one-hot 1-cycle completion pulse (during RESP)
//   rsp_data       : completion data, valid with rsp_valid
//   bus            : master modport towards wb_interface
// All outputs are registered.
// Build option: WB_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) and removes the round-robin pointer.
// ---------------------------------------------------------------------------
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DATA_WL = DATA_WL_DEF,
  parameter int ADR_WL  = ADR_WL_DEF
) (
  input  logic                       clk,
  input  logic                       a_reset_l,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADR_WL-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WL-1:0] req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_WL-1:0]         rsp_data,
  wb_master_arbiter_if.master        bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;   // last granted requester
  logic [IDX_W-1:0] cur_q;   // requester owning the transaction in flight
  logic [IDX_W-1:0] win;
  logic             any;
  logic             grant_d; // accept a request this cycle
  logic             done_d;  // completion seen this cycle

  wb_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // State register.
  always_ff @(posedge clk or negedge a_reset_l) begin
    // NOTE: sequential state is updated with non-blocking '<=' so every
    // flop samples pre-edge values regardless of statement order.
    if (!a_reset_l) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      // A stale valid from the previous transaction cannot be seen here:
      // wb_interface clears it on the start edge that leaves ISSUE.
      ST_WAIT:  if (!bus.busy && bus.valid) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; the pulses it produces are registered below so they are
  // high during ISSUE and RESP respectively.
  always_comb begin
    grant_d = (state_q == ST_IDLE) && any;
    done_d  = (state_q == ST_WAIT) && !bus.busy && bus.valid;
  end

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      bus.start <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      cur_q     <= '0;
    end else begin
      bus.start <= grant_d;
      gnt       <= grant_d ? (NUM_REQ'(1) << win) : '0;
      rsp_valid <= done_d  ? (NUM_REQ'(1) << cur_q) : '0;
      if (grant_d) begin
        bus.we    <= req_we[win];
        bus.addr  <= req_addr[int'(win) * ADR_WL +: ADR_WL];
        bus.wdata <= req_data[int'(win) * DATA_WL +: DATA_WL];
        cur_q     <= win;
      end
      // Captured for writes too; the value is then whatever the slave returned.
      if (done_d) rsp_data <= bus.rdata;
    end
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  assign ptr_q = IDX_W'(NUM_REQ - 1);
`else
  // Reset to NUM_REQ-1 so the first search starts at requester 0.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l)   ptr_q <= IDX_W'(NUM_REQ - 1);
    else if (grant_d) ptr_q <= win;
  end
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_master_arbiter
// Directed bench for wb_master_arbiter with a behavioural wb_interface
// slave (programmable ack delay). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        a_reset_l = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  gnt, rsp_valid;
  logic [15:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  wb_master_arbiter_if #(.DATA_WL(16), .ADR_WL(16)) bus ();

  wb_master_arbiter #(.NUM_REQ(4), .IDX_W(2), .DATA_WL(16), .ADR_WL(16)) dut (
    .clk       (clk),
    .a_reset_l (a_reset_l),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural slave: start -> busy, valid cleared; after slave_delay extra
  // cycles busy falls and valid rises with slave_rdata.
  int          slave_delay = 0;
  logic [15:0] slave_rdata = '0;
  int          cnt;

  always @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      bus.busy <= 1'b0; bus.valid <= 1'b0; bus.rdata <= '0; cnt <= 0;
    end else if (bus.start) begin
      bus.busy <= 1'b1; bus.valid <= 1'b0; cnt <= slave_delay;
    end else if (bus.busy) begin
      if (cnt == 0) begin
        bus.busy <= 1'b0; bus.valid <= 1'b1; bus.rdata <= slave_rdata;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Protocol monitors.
  int cyc = 0;
  int start_cnt = 0;
  int multi_gnt = 0;
  int start_in_busy = 0;
  always @(negedge clk) begin
    cyc++;
    if (a_reset_l) begin
      if (bus.start) start_cnt++;
      if ($countones(gnt) > 1) multi_gnt++;
      if (bus.start && bus.busy) start_in_busy++;
    end
  end

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != 0) begin g = gnt; break; end
    end
  endtask

  task automatic wait_rsp(output logic [3:0] rv, output logic [15:0] rd);
    rv = '0; rd = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin rv = rsp_valid; rd = rsp_data; break; end
    end
  endtask

  task automatic do_reset();
    a_reset_l = 1'b0;
    repeat (2) @(negedge clk);
    a_reset_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0]  g, rv;
    logic [15:0] rd;
    @(negedge clk);
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data} !== 24'h0) begin
      n_bad++; $display("FAIL reset_rsp: got %h required 0", {gnt, rsp_valid, rsp_data});
    end
    n_cmp++;
    if ({bus.start, bus.we, bus.addr, bus.wdata} !== 34'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h required 0", {bus.start, bus.we, bus.addr, bus.wdata});
    end
    a_reset_l = 1'b1;
    @(negedge clk);
    // Requester 0 starts a long transaction, then reset hits mid-WAIT.
    slave_delay = 20;
    req = 4'b0001;
    wait_gnt(g);
    req = 4'b0000;
    n_cmp++;
    if (g !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b required 0001", g); end
    repeat (3) @(negedge clk);
    a_reset_l = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data, bus.start, bus.we, bus.addr, bus.wdata} !== 58'h0) begin
      n_bad++; $display("FAIL reset_mid_wait: got %h required 0",
                        {gnt, rsp_valid, rsp_data, bus.start, bus.we, bus.addr, bus.wdata});
    end
    a_reset_l = 1'b1;
    slave_delay = 1;
    @(negedge clk);
    // Pointer back at 3: requester 0 beats 1 (a stale pointer of 0 would pick 1).
    req = 4'b0011;
    wait_gnt(g);
    req = 4'b0000;
    n_cmp++;
    if (g !== 4'b0001) begin n_bad++; $display("FAIL reset_ptr_restore: got %b required 0001", g); end
    wait_rsp(rv, rd);
    n_cmp++;
    if (rv !== 4'b0001) begin n_bad++; $display("FAIL reset_after_rsp: got %b required 0001", rv); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    logic [3:0]  g, rv;
    logic [15:0] rd;
    slave_delay = 2;
    slave_rdata = 16'hBEEF;
    req_we = 4'b0000;
    req_addr[32 +: 16] = 16'h0040;
    req = 4'b0100;
    wait_gnt(g);
    req = 4'b0000;
    n_cmp++;
    if (g !== 4'b0100) begin n_bad++; $display("FAIL read_gnt: got %b required 0100", g); end
    n_cmp++;
    if (bus.start !== 1'b1) begin n_bad++; $display("FAIL read_start: got %b required 1", bus.start); end
    n_cmp++;
    if ({bus.we, bus.addr} !== {1'b0, 16'h0040}) begin
      n_bad++; $display("FAIL read_cmd: got we=%b addr=%h required we=0 addr=0040", bus.we, bus.addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({gnt, bus.start} !== 5'b0) begin
      n_bad++; $display("FAIL read_pulse_width: got gnt=%b start=%b required 0", gnt, bus.start);
    end
    wait_rsp(rv, rd);
    n_cmp++;
    if (rv !== 4'b0100) begin n_bad++; $display("FAIL read_rsp_valid: got %b required 0100", rv); end
    n_cmp++;
    if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL read_rsp_data: got %h required beef", rd); end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL read_rsp_width: got %b required 0000", rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [3:0]  g, rv;
    logic [15:0] rd;
    int s0;
    s0 = start_cnt;
    slave_delay = 1;
    req_we = 4'b0010;
    req_addr[16 +: 16] = 16'h0010;
    req_data[16 +: 16] = 16'h1234;
    req = 4'b0010;
    wait_gnt(g);
    req = 4'b0000;
    req_we = 4'b0000;
    n_cmp++;
    if (g !== 4'b0010) begin n_bad++; $display("FAIL write_gnt: got %b required 0010", g); end
    n_cmp++;
    if ({bus.we, bus.addr, bus.wdata} !== {1'b1, 16'h0010, 16'h1234}) begin
      n_bad++; $display("FAIL write_cmd: got we=%b addr=%h data=%h required 1/0010/1234",
                        bus.we, bus.addr, bus.wdata);
    end
    wait_rsp(rv, rd);
    n_cmp++;
    if (rv !== 4'b0010) begin n_bad++; $display("FAIL write_rsp_valid: got %b required 0010", rv); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (start_cnt - s0 !== 1) begin
      n_bad++; $display("FAIL write_start_count: got %0d required 1", start_cnt - s0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g, exp;
    int t[5];
    int mg0, sb0;
    do_reset();
    mg0 = multi_gnt; sb0 = start_in_busy;
    slave_delay = 0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      t[k] = cyc;
      exp = 4'b0001 << (k % 4);
      n_cmp++;
      if (g !== exp) begin n_bad++; $display("FAIL rr_order[%0d]: got %b required %b", k, g, exp); end
    end
    req = 4'b0000;
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (t[k] - t[k-1] !== 5) begin
        n_bad++; $display("FAIL rr_turnaround[%0d]: got %0d required 5", k, t[k] - t[k-1]);
      end
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (multi_gnt - mg0 !== 0) begin n_bad++; $display("FAIL rr_onehot: got %0d multi-bit grants required 0", multi_gnt - mg0); end
    n_cmp++;
    if (start_in_busy - sb0 !== 0) begin n_bad++; $display("FAIL rr_start_in_wait: got %0d required 0", start_in_busy - sb0); end
  endtask

  task automatic test_slow_ack();
    logic [3:0] g, rv;
    int fall, rsp_at, pulses;
    fall = -1; rsp_at = -1; pulses = 0; rv = '0;
    slave_delay = 10;
    slave_rdata = 16'h5A5A;
    req_addr[48 +: 16] = 16'h0030;
    req = 4'b1000;
    wait_gnt(g);
    req = 4'b0000;
    n_cmp++;
    if (g !== 4'b1000) begin n_bad++; $display("FAIL slow_gnt: got %b required 1000", g); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin rsp_at = i; rv = rsp_valid; break; end
      if (fall < 0 && !bus.busy && bus.valid) fall = i;
      if (gnt != 0 || bus.start) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL slow_no_pulses: got %0d required 0", pulses); end
    n_cmp++;
    if (rv !== 4'b1000) begin n_bad++; $display("FAIL slow_rsp_valid: got %b required 1000", rv); end
    n_cmp++;
    if (fall !== 11 || rsp_at !== 12) begin
      n_bad++; $display("FAIL slow_rsp_timing: got fall=%0d rsp=%0d required 11/12", fall, rsp_at);
    end
    n_cmp++;
    if (rsp_data !== 16'h5A5A) begin n_bad++; $display("FAIL slow_rsp_data: got %h required 5a5a", rsp_data); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    logic [3:0] g;
    logic [3:0] exp[3];
`ifdef WB_ARB_FIXED_PRIO_EN
    exp = '{4'b0010, 4'b0010, 4'b0010};
`else
    exp = '{4'b0010, 4'b1000, 4'b0010};
`endif
    do_reset();
    slave_delay = 0;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(g);
      n_cmp++;
      if (g !== exp[k]) begin n_bad++; $display("FAIL prio_order[%0d]: got %b required %b", k, g, exp[k]); end
    end
    req = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_slow_ack();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
